// File: rtl/coinc_pkg.sv
// Shared constants and types for the coincidence counter.
// The COINC_DEADTIME_EN macro enables per-channel dead time in coinc_edge_sync.
package coinc_pkg;

    // Width of every singles/coincidence counter
    localparam int CNT_W = 20;

    // Default build parameters: 1 ms gate, 20 ns window, 200 ns dead time at 400 MHz
    localparam int GATE_DEF = 400000;
    localparam int WIN_DEF  = 8;
    localparam int DEAD_DEF = 80;

    typedef logic [CNT_W-1:0] cnt_t;

    // Saturation ceiling shared by all counters
    localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/coinc_edge_sync.sv
// Detector input conditioning for one channel: 2-FF synchronizer, rising-edge
// detector and, when COINC_DEADTIME_EN is defined, a dead timer that suppresses
// re-triggering for DEAD cycles after each accepted event.
// Without COINC_DEADTIME_EN every synchronized rising edge is passed through
// and DEAD has no effect.
module coinc_edge_sync
    import coinc_pkg::*;
#(
    parameter int DEAD = DEAD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_i,
    output logic evt_o
);

    // [0],[1]: metastability chain, [2]: previous synchronized level
    logic [2:0] sync_q;
    logic       rise;

    // Shift the asynchronous input through the synchronizer and edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], pulse_i};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

`ifdef COINC_DEADTIME_EN
    // Timer holds the remaining blocked cycles; zero means the channel is live.
    localparam int DW = (DEAD > 1) ? $clog2(DEAD) : 1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'((DEAD > 0) ? DEAD - 1 : 0);

    logic [DW-1:0] dead_q;
    logic [DW-1:0] dead_d;
    logic          accept;

    assign accept = rise & (dead_q == '0);

    // Reload on every accepted event, otherwise count down to zero
    always_comb begin
        dead_d = dead_q;
        if (accept) begin
            dead_d = DEAD_LOAD;
        end else if (dead_q != '0) begin
            dead_d = dead_q - 1'b1;
        end
    end

    // Dead timer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end

    assign evt_o = accept;
`else
    assign evt_o = rise;
`endif

endmodule

// File: rtl/coinc_counter.sv
// Two-channel singles and coincidence counter with a fixed counting gate.
// Each gate of GATE cycles produces cnt_a/cnt_b/cnt_ab/ovf and a one-cycle
// valid strobe. Optional dead time is enabled with COINC_DEADTIME_EN.
module coinc_counter
    import coinc_pkg::*;
#(
    parameter int GATE = GATE_DEF,
    parameter int WIN  = WIN_DEF,
    parameter int DEAD = DEAD_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ch_a,
    input  logic             ch_b,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_ab,
    output logic             valid,
    output logic             ovf
);

    localparam int GW = (GATE > 1) ? $clog2(GATE) : 1;
    localparam int WW = (WIN > 0) ? $clog2(WIN + 1) : 1;

    // Saturating increment by one when en is set
    function automatic cnt_t sat_inc(input cnt_t v, input logic en);
        return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
    endfunction

    // True when an increment is requested on an already saturated counter
    function automatic logic sat_hit(input cnt_t v, input logic en);
        return en && (v == CNT_MAX);
    endfunction

    logic evt_a;
    logic evt_b;

    coinc_edge_sync #(.DEAD(DEAD)) u_sync_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_i (ch_a),
        .evt_o   (evt_a)
    );

    coinc_edge_sync #(.DEAD(DEAD)) u_sync_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_i (ch_b),
        .evt_o   (evt_b)
    );

    logic [GW-1:0] gate_q, gate_d;
    logic [WW-1:0] win_a_q, win_a_d;
    logic [WW-1:0] win_b_q, win_b_d;
    cnt_t          run_a_q, run_a_d;
    cnt_t          run_b_q, run_b_d;
    cnt_t          run_ab_q, run_ab_d;
    logic          ovf_run_q, ovf_run_d;
    cnt_t          cnt_a_q, cnt_b_q, cnt_ab_q;
    logic          valid_q, ovf_q;

    logic          term;
    logic          open_a, open_b;
    logic          coinc;
    cnt_t          tot_a, tot_b, tot_ab;
    logic          ovf_now;

    assign term   = (gate_q == GW'(GATE - 1));
    assign open_a = (win_a_q != '0);
    assign open_b = (win_b_q != '0);
    assign coinc  = (evt_a & evt_b) | (evt_a & open_b) | (evt_b & open_a);

    // Running totals including this cycle's events, so terminal-cycle events land in the closing gate
    assign tot_a   = sat_inc(run_a_q, evt_a);
    assign tot_b   = sat_inc(run_b_q, evt_b);
    assign tot_ab  = sat_inc(run_ab_q, coinc);
    assign ovf_now = ovf_run_q | sat_hit(run_a_q, evt_a) | sat_hit(run_b_q, evt_b)
                   | sat_hit(run_ab_q, coinc);

    // Gate counter wraps at GATE-1; window timers are untouched by rollover
    always_comb begin
        gate_d = term ? '0 : gate_q + 1'b1;

        win_a_d = win_a_q;
        win_b_d = win_b_q;
        if (coinc) begin
            // Both events are consumed, so neither may pair again
            win_a_d = '0;
            win_b_d = '0;
        end else begin
            if (evt_a) begin
                win_a_d = WW'(WIN);
            end else if (open_a) begin
                win_a_d = win_a_q - 1'b1;
            end
            if (evt_b) begin
                win_b_d = WW'(WIN);
            end else if (open_b) begin
                win_b_d = win_b_q - 1'b1;
            end
        end

        run_a_d   = term ? '0 : tot_a;
        run_b_d   = term ? '0 : tot_b;
        run_ab_d  = term ? '0 : tot_ab;
        ovf_run_d = term ? 1'b0 : ovf_now;
    end

    // Gate, window and running-count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q    <= '0;
            win_a_q   <= '0;
            win_b_q   <= '0;
            run_a_q   <= '0;
            run_b_q   <= '0;
            run_ab_q  <= '0;
            ovf_run_q <= 1'b0;
        end else begin
            gate_q    <= gate_d;
            win_a_q   <= win_a_d;
            win_b_q   <= win_b_d;
            run_a_q   <= run_a_d;
            run_b_q   <= run_b_d;
            run_ab_q  <= run_ab_d;
            ovf_run_q <= ovf_run_d;
        end
    end

    // Publish results at gate end and hold them until the next gate end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            cnt_ab_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= term;
            if (term) begin
                cnt_a_q  <= tot_a;
                cnt_b_q  <= tot_b;
                cnt_ab_q <= tot_ab;
                ovf_q    <= ovf_now;
            end
        end
    end

    assign cnt_a  = cnt_a_q;
    assign cnt_b  = cnt_b_q;
    assign cnt_ab = cnt_ab_q;
    assign valid  = valid_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_coinc_counter.sv
// Self-checking bench for coinc_counter (GATE=100, WIN=8, DEAD=20).
// Directed scenarios followed by random pulses, all checked every cycle
// against a timestamp-based reference model.
module tb_coinc_counter;

    localparam int GATE = 100;
    localparam int WIN  = 8;
    localparam int DEAD = 20;
    localparam int SYNC_LAT = 3;

`ifdef COINC_DEADTIME_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ch_a = 1'b0;
    logic        ch_b = 1'b0;
    logic [19:0] cnt_a, cnt_b, cnt_ab;
    logic        valid, ovf;

    coinc_counter #(.GATE(GATE), .WIN(WIN), .DEAD(DEAD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ch_a   (ch_a),
        .ch_b   (ch_b),
        .cnt_a  (cnt_a),
        .cnt_b  (cnt_b),
        .cnt_ab (cnt_ab),
        .valid  (valid),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: pc counts clock edges since reset release
    int pc;
    int qa[$];
    int qb[$];
    bit prev_a, prev_b;
    bit have_a, have_b;
    int ta, tb_t;
    bit acc_a, acc_b;
    int la, lb;
    int m_a, m_b, m_ab;
    int s_a, s_b, s_ab;
    bit s_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit live(input bit any, input int last);
        return !DT_EN || !any || ((pc - last) >= DEAD);
    endfunction

    function automatic int sat(input int v);
        return (v > 20'hFFFFF) ? 20'hFFFFF : v;
    endfunction

    task automatic model_reset();
        pc = 0;
        qa.delete();
        qb.delete();
        prev_a = 0; prev_b = 0;
        have_a = 0; have_b = 0;
        ta = 0; tb_t = 0;
        acc_a = 0; acc_b = 0;
        la = 0; lb = 0;
        m_a = 0; m_b = 0; m_ab = 0;
        s_a = 0; s_b = 0; s_ab = 0;
        s_valid = 0;
    endtask

    // One clock edge of the model: pair events by timestamp distance
    task automatic model_edge();
        bit ra, rb, ea, eb, opa, opb, co;
        int g;
        ra = (qa.size() > 0) && (qa[0] == pc);
        rb = (qb.size() > 0) && (qb[0] == pc);
        if (ra) void'(qa.pop_front());
        if (rb) void'(qb.pop_front());
        ea = ra && live(acc_a, la);
        eb = rb && live(acc_b, lb);
        if (ea) begin acc_a = 1; la = pc; end
        if (eb) begin acc_b = 1; lb = pc; end
        opa = have_a && ((pc - ta) <= WIN);
        opb = have_b && ((pc - tb_t) <= WIN);
        co  = (ea && eb) || (ea && opb) || (eb && opa);
        if (co) begin
            have_a = 0;
            have_b = 0;
        end else begin
            if (ea) begin have_a = 1; ta = pc; end
            if (eb) begin have_b = 1; tb_t = pc; end
        end
        m_a  = sat(m_a + int'(ea));
        m_b  = sat(m_b + int'(eb));
        m_ab = sat(m_ab + int'(co));
        g = (pc - 1) % GATE;
        s_valid = (g == GATE - 1);
        if (s_valid) begin
            s_a = m_a; s_b = m_b; s_ab = m_ab;
            m_a = 0; m_b = 0; m_ab = 0;
        end
    endtask

    // Called at a falling edge: drive inputs, advance one clock, check outputs
    task automatic step(input bit a, input bit b);
        ch_a = a;
        ch_b = b;
        if (a && !prev_a) qa.push_back(pc + SYNC_LAT);
        if (b && !prev_b) qb.push_back(pc + SYNC_LAT);
        prev_a = a;
        prev_b = b;
        @(posedge clk);
        pc++;
        model_edge();
        #1;
        chk("valid", {31'd0, valid}, {31'd0, s_valid});
        chk("cnt_a", {12'd0, cnt_a}, s_a);
        chk("cnt_b", {12'd0, cnt_b}, s_b);
        chk("cnt_ab", {12'd0, cnt_ab}, s_ab);
        chk("ovf", {31'd0, ovf}, 0);
        @(negedge clk);
    endtask

    task automatic drive_until(input int t);
        while (pc < t) step(0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cnt_a"}, {12'd0, cnt_a}, 0);
        chk({tag, "_cnt_b"}, {12'd0, cnt_b}, 0);
        chk({tag, "_cnt_ab"}, {12'd0, cnt_ab}, 0);
        chk({tag, "_valid"}, {31'd0, valid}, 0);
        chk({tag, "_ovf"}, {31'd0, ovf}, 0);
    endtask

    // Called at a falling edge: assert reset, check async clear, release at a falling edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        ch_a = 1'b0;
        ch_b = 1'b0;
        model_reset();
        #1;
        check_reset_outputs(tag);
        repeat (3) @(negedge clk);
        check_reset_outputs({tag, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, %0d checks so far", n_assert);
        $fatal(1, "timeout");
    end

    initial begin
        bit ra, rb;
        model_reset();
        do_reset("rst0");

        // Gate 1: A at cycles 10 and 50, B at 13
        drive_until(8);  step(1, 0);
        drive_until(11); step(0, 1);
        drive_until(48); step(1, 0);
        drive_until(100);
        chk("g1_valid", {31'd0, valid}, 1);
        chk("g1_cnt_a", {12'd0, cnt_a}, 2);
        chk("g1_cnt_b", {12'd0, cnt_b}, 1);
        chk("g1_cnt_ab", {12'd0, cnt_ab}, 1);

        // Gate 2: A and B together, then B 12 cycles later
        drive_until(110); step(1, 1);
        drive_until(122); step(0, 1);
        drive_until(200);
        chk("g2_cnt_a", {12'd0, cnt_a}, 1);
        chk("g2_cnt_b", {12'd0, cnt_b}, DT_EN ? 1 : 2);
        chk("g2_cnt_ab", {12'd0, cnt_ab}, 1);

        // Gate 3: A, B at +3, B at +5 -> only one coincidence
        drive_until(210); step(1, 0);
        drive_until(213); step(0, 1);
        drive_until(215); step(0, 1);
        drive_until(300);
        chk("g3_cnt_a", {12'd0, cnt_a}, 1);
        chk("g3_cnt_b", {12'd0, cnt_b}, DT_EN ? 1 : 2);
        chk("g3_cnt_ab", {12'd0, cnt_ab}, 1);

        // Gate 4/5: A at gate cycle 97, B at cycle 101 straddles the rollover
        drive_until(395); step(1, 0);
        drive_until(399); step(0, 1);
        drive_until(400);
        chk("g4_valid", {31'd0, valid}, 1);
        chk("g4_cnt_a", {12'd0, cnt_a}, 1);
        chk("g4_cnt_b", {12'd0, cnt_b}, 0);
        chk("g4_cnt_ab", {12'd0, cnt_ab}, 0);

        // Gate 5: three A pulses 10 cycles apart
        drive_until(420); step(1, 0);
        drive_until(430); step(1, 0);
        drive_until(440); step(1, 0);
        drive_until(500);
        chk("g5_cnt_a", {12'd0, cnt_a}, DT_EN ? 2 : 3);
        chk("g5_cnt_b", {12'd0, cnt_b}, 1);
        chk("g5_cnt_ab", {12'd0, cnt_ab}, 1);

        // Gates 6..9: random single-cycle pulses on both channels
        while (pc < 900) begin
            ra = !prev_a && ($urandom_range(0, 5) == 0);
            rb = !prev_b && ($urandom_range(0, 5) == 0);
            step(ra, rb);
        end

        // Gate 10: five A events, then reset at gate cycle 60
        drive_until(905);
        for (int i = 0; i < 5; i++) begin
            step(1, 0);
            step(0, 0);
        end
        drive_until(960);
        do_reset("rst1");
        repeat (GATE - 1) step(0, 0);
        chk("post_rst_no_strobe", {31'd0, valid}, 0);
        step(0, 0);
        chk("post_rst_valid", {31'd0, valid}, 1);
        chk("post_rst_cnt_a", {12'd0, cnt_a}, 0);
        chk("post_rst_cnt_b", {12'd0, cnt_b}, 0);
        chk("post_rst_cnt_ab", {12'd0, cnt_ab}, 0);
        step(0, 0);
        chk("post_rst_strobe_len", {31'd0, valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
